systolic_skew_feeder: RTL

Upstream stage of the 4x4 systolic multiplier. It latches two NxN operand matrices A and B on a start request. It then drives the array's left edge (rows) and top edge (columns) with diagonally skewed, zero-padded operand streams. It also pulses the array's reset to clear the PE accumulators before each run and signals when the array result is settled.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/feeder_lane.sv | 28 ++
 rtl/systolic_skew_feeder.sv | 118 +++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared sizing, FSM state encoding and matrix element indexing for the systolic skew feeder.
package systolic_pkg;

  localparam int DATA_W   = 32;
  localparam int N        = 4;
  localparam int FEED_LEN = 3 * N - 2;
  localparam int CNT_W    = (FEED_LEN > 1) ? $clog2(FEED_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int elem_idx(input int r, input int c, input int n = N);
    return r * n + c;
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One skewed operand lane: emits element (cnt - lane) of its N-element vector, zero outside that window.
// Purely combinational from registered inputs; no backpressure.
module feeder_lane
  import systolic_pkg::*;
(
  input  logic [N*DATA_W-1:0] elems_i,
  input  logic [CNT_W-1:0]    lane_i,
  input  logic [CNT_W-1:0]    cnt_i,
  input  logic                feed_valid_i,
  output logic [DATA_W-1:0]   elem_o
);

  // Two extra bits so cnt - lane goes negative instead of wrapping into the window.
  logic signed [CNT_W+1:0] w_off;

  always_comb begin
    w_off  = $signed({2'b00, cnt_i}) - $signed({2'b00, lane_i});
    elem_o = '0;
    if (feed_valid_i) begin
      for (int k = 0; k < N; k++) begin
        if (w_off == (CNT_W+2)'(k)) begin
          elem_o = elems_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Latches A/B on start, clears the array for one cycle, then feeds FEED_LEN cycles of skewed operands and pulses done_o.
// B_COLMAJOR_EN: when defined, b_mat_i is column-major; otherwise row-major.
module systolic_skew_feeder
  import systolic_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [N*N*DATA_W-1:0] a_mat_i,
  input  logic [N*N*DATA_W-1:0] b_mat_i,
  output logic [N*DATA_W-1:0]   left_o,
  output logic [N*DATA_W-1:0]   up_o,
  output logic                  array_rst_no,
  output logic                  busy_o,
  output logic                  feed_valid_o,
  output logic                  done_o
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [N*N*DATA_W-1:0] r_a;
  logic [N*N*DATA_W-1:0] r_b;
  logic                  w_latch;
  logic                  w_clear;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_a <= a_mat_i;
        r_b <= b_mat_i;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    w_clear      = 1'b0;
    busy_o       = 1'b1;
    feed_valid_o = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o    = 1'b0;
        w_cnt_nxt = '0;
        if (start_i) begin
          w_latch     = 1'b1;
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        w_clear     = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = FEED;
      end
      FEED: begin
        feed_valid_o = 1'b1;
        if (r_cnt == CNT_W'(FEED_LEN - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Held low during reset itself as well as for the CLEAR cycle.
  assign array_rst_no = rst_ni & ~w_clear;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [N*DATA_W-1:0] w_row;
    logic [N*DATA_W-1:0] w_col;

    for (genvar gk = 0; gk < N; gk++) begin : g_elem
      assign w_row[gk*DATA_W +: DATA_W] = r_a[elem_idx(gi, gk)*DATA_W +: DATA_W];
`ifdef B_COLMAJOR_EN
      assign w_col[gk*DATA_W +: DATA_W] = r_b[elem_idx(gi, gk)*DATA_W +: DATA_W];
`else
      assign w_col[gk*DATA_W +: DATA_W] = r_b[elem_idx(gk, gi)*DATA_W +: DATA_W];
`endif
    end

    feeder_lane u_row (
      .elems_i      (w_row),
      .lane_i       (CNT_W'(gi)),
      .cnt_i        (r_cnt),
      .feed_valid_i (feed_valid_o),
      .elem_o       (left_o[gi*DATA_W +: DATA_W])
    );

    feeder_lane u_col (
      .elems_i      (w_col),
      .lane_i       (CNT_W'(gi)),
      .cnt_i        (r_cnt),
      .feed_valid_i (feed_valid_o),
      .elem_o       (up_o[gi*DATA_W +: DATA_W])
    );
  end

endmodule
